// File: rtl/alu_pkg.sv
// Shared types and constants for the multiword 74181 sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  // {M, S[3:0]} pairs for the active-high-data 74181 functions in common use
  localparam logic [4:0] OP_ADD    = {1'b0, 4'b1001};
  localparam logic [4:0] OP_SUB    = {1'b0, 4'b0110};
  localparam logic [4:0] OP_AND    = {1'b1, 4'b1011};
  localparam logic [4:0] OP_OR     = {1'b1, 4'b1110};
  localparam logic [4:0] OP_XOR    = {1'b1, 4'b0110};
  localparam logic [4:0] OP_PASS_A = {1'b1, 4'b1111};

  function automatic int unsigned eff_words(input int unsigned req,
                                            input int unsigned max_words);
    if (req == 0) return 1;
    if (req > max_words) return max_words;
    return req;
  endfunction

endpackage

// File: rtl/alu_multiword_seq.sv
// Sequences a multiword operation through an external 74181 slice chain,
// one word per cycle low word first, and presents result plus C/Z/N flags.
module alu_multiword_seq #(
  parameter int WIDTH = 8,
  parameter int WORDS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [WIDTH*WORDS-1:0]     op_a,
  input  logic [WIDTH*WORDS-1:0]     op_b,
  input  logic [3:0]                 op_s,
  input  logic                       op_m,
  input  logic                       op_cin,
  input  logic [$clog2(WORDS+1)-1:0] op_words,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [3:0]                 alu_s,
  output logic                       alu_m,
  output logic                       alu_cnb,
  input  logic [WIDTH-1:0]           alu_f,
  input  logic                       alu_cn4b,
  input  logic                       alu_aeb,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH*WORDS-1:0]     res_data,
  output logic                       flag_c,
  output logic                       flag_z,
  output logic                       flag_n
);
  import alu_pkg::*;

  localparam int CW = $clog2(WORDS + 1);
  localparam int RW = WIDTH * WORDS;

  state_e          state_q, state_d;
  logic [RW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]      s_q, s_d;
  logic            m_q, m_d, cin_q, cin_d;
  logic [CW-1:0]   n_q, n_d, idx_q, idx_d;
  logic            cn4b_q, cn4b_d, nz_q, nz_d;
  logic            fc_q, fc_d, fz_q, fz_d, fn_q, fn_d;
  logic            last_word;

  assign last_word = (idx_q == n_q - CW'(1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    m_d       = m_q;
    cin_d     = cin_q;
    n_d       = n_q;
    idx_d     = idx_q;
    res_d     = res_q;
    cn4b_d    = cn4b_q;
    nz_d      = nz_q;
    fc_d      = fc_q;
    fz_d      = fz_q;
    fn_d      = fn_q;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_s     = '0;
    alu_m     = 1'b1;
    alu_cnb   = 1'b1;

    case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          s_d     = op_s;
          m_d     = op_m;
          cin_d   = op_cin;
          n_d     = CW'(eff_words(32'(op_words), WORDS));
          res_d   = '0;
          idx_d   = '0;
          nz_d    = 1'b0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        alu_a   = a_q[idx_q*WIDTH +: WIDTH];
        alu_b   = b_q[idx_q*WIDTH +: WIDTH];
        alu_s   = s_q;
        alu_m   = m_q;
        alu_cnb = (idx_q == '0) ? ~cin_q : cn4b_q;
        res_d[idx_q*WIDTH +: WIDTH] = alu_f;
        cn4b_d  = alu_cn4b;
        nz_d    = nz_q | alu_aeb;
        if (last_word) begin
          // Logic-mode ops leave the carry flag untouched
          fc_d    = m_q ? fc_q : ~alu_cn4b;
          fz_d    = ~(nz_q | alu_aeb);
          fn_d    = alu_f[WIDTH-1];
          state_d = DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end

      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b1;
      cin_q   <= 1'b0;
      n_q     <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      cn4b_q  <= 1'b1;
      nz_q    <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      cin_q   <= cin_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      cn4b_q  <= cn4b_d;
      nz_q    <= nz_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      fn_q    <= fn_d;
    end
  end

  assign res_data = res_q;
  assign flag_c   = fc_q;
  assign flag_z   = fz_q;
  assign flag_n   = fn_q;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Bench: sequencer driving two chained behavioural 74181 slices (WIDTH=8, WORDS=2).
module tb_alu_multiword_seq;
  import alu_pkg::*;

  logic        clk, rst_n;
  logic        op_valid, op_ready;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_s;
  logic        op_m, op_cin;
  logic [1:0]  op_words;
  logic [7:0]  alu_a, alu_b, alu_f;
  logic [3:0]  alu_s;
  logic        alu_m, alu_cnb, alu_cn4b, alu_aeb;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        flag_c, flag_z, flag_n;

  int checks = 0;
  int errors = 0;
  logic prev_c;

  alu_multiword_seq #(.WIDTH(8), .WORDS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .op_words(op_words),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cnb(alu_cnb),
    .alu_f(alu_f), .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 74181 slice, active-high data: {Cn+4 (active low), F}
  function automatic logic [4:0] slice181(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s, input logic m,
                                          input logic cnb);
    logic [3:0] x, y;
    logic [4:0] sum;
    x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0, ~cnb};
    return {~sum[4], m ? ~(x ^ y) : sum[3:0]};
  endfunction

  logic [4:0] lo, hi;
  always_comb begin
    lo       = slice181(alu_a[3:0], alu_b[3:0], alu_s, alu_m, alu_cnb);
    hi       = slice181(alu_a[7:4], alu_b[7:4], alu_s, alu_m, lo[4]);
    alu_f    = {hi[3:0], lo[3:0]};
    alu_cn4b = hi[4];
    alu_aeb  = |alu_f;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] op_code(input int sel);
    case (sel)
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_AND;
      3: return OP_OR;
      4: return OP_XOR;
      default: return OP_PASS_A;
    endcase
  endfunction

  // Issue one op, check each word's ALU drive, latency, result, hold and release.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [1:0] words, input int hold,
                        input bit keep_valid);
    logic [4:0]  ms;
    int          n, k;
    bit          arith;
    logic [31:0] a32, b32, bx, mask, mk, full, res_e, cin_k;
    logic        c_e, z_e, n_e;
    ms    = op_code(sel);
    arith = (sel <= 1);
    n     = (words == 2'd0) ? 1 : ((words > 2'd2) ? 2 : int'(words));
    a32   = 32'(a);
    b32   = 32'(b);
    bx    = (sel == 1) ? ~b32 : b32;
    mask  = (32'd1 << (8 * n)) - 32'd1;
    full  = 32'd0;
    case (sel)
      0, 1: full = (a32 & mask) + (bx & mask) + 32'(cin);
      2:    full = a32 & b32;
      3:    full = a32 | b32;
      4:    full = a32 ^ b32;
      default: full = a32;
    endcase
    res_e = full & mask;
    c_e   = arith ? full[8 * n] : prev_c;
    z_e   = (res_e == 32'd0);
    n_e   = res_e[8 * n - 1];

    op_a = a; op_b = b; op_s = ms[3:0]; op_m = ms[4]; op_cin = cin;
    op_words = words; op_valid = 1'b1;
    chk("op_ready_idle", 32'(op_ready), 32'd1);
    @(posedge clk); #1;
    if (!keep_valid) begin
      op_valid = 1'b0;
      op_a = 16'($urandom); op_b = 16'($urandom); op_s = 4'($urandom); op_cin = ~cin;
    end
    chk("op_ready_exec", 32'(op_ready), 32'd0);

    k = 0;
    while (!res_valid && k < 16) begin
      if (k < n) begin
        chk("alu_a", 32'(alu_a), (a32 >> (8 * k)) & 32'hFF);
        chk("alu_b", 32'(alu_b), (b32 >> (8 * k)) & 32'hFF);
        chk("alu_s", 32'(alu_s), 32'(ms[3:0]));
        chk("alu_m", 32'(alu_m), 32'(ms[4]));
        if (arith || k == 0) begin
          mk    = (32'd1 << (8 * k)) - 32'd1;
          cin_k = (((a32 & mk) + (bx & mk) + 32'(cin)) >> (8 * k)) & 32'd1;
          chk("alu_cnb", 32'(alu_cnb), cin_k ^ 32'd1);
        end
      end
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(n));
    chk("res_data", 32'(res_data), res_e);
    chk("flag_c", 32'(flag_c), 32'(c_e));
    chk("flag_z", 32'(flag_z), 32'(z_e));
    chk("flag_n", 32'(flag_n), 32'(n_e));

    res_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), res_e);
      chk("hold_flags", 32'({flag_c, flag_z, flag_n}), 32'({c_e, z_e, n_e}));
      chk("hold_op_ready", 32'(op_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("op_ready_back", 32'(op_ready), 32'd1);
    prev_c = c_e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0;
    op_cin = 1'b0; op_words = '0; res_ready = 1'b0; prev_c = 1'b0;
    #3;
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_s, alu_m, alu_cnb}), 32'b11);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 16'h00FF, 16'h0001, 1'b0, 2'd2, 0, 0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 2'd2, 0, 0);
    run_op(4, 16'h005A, 16'h005A, 1'b0, 2'd1, 0, 0);

    // Reset while word 0 is executing; flags were C=1, Z=1 beforehand
    op_a = 16'h1234; op_b = 16'h1111; op_s = OP_ADD[3:0]; op_m = OP_ADD[4];
    op_cin = 1'b1; op_words = 2'd2; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("pre_rst_exec", 32'(op_ready), 32'd0);
    rst_n = 1'b0; #1;
    chk("midrst_op_ready", 32'(op_ready), 32'd1);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    chk("midrst_res_data", 32'(res_data), 32'd0);
    chk("midrst_alu", 32'({alu_m, alu_cnb}), 32'b11);
    #2 rst_n = 1'b1;
    prev_c = 1'b0;
    @(posedge clk); #1;

    run_op(1, 16'h0100, 16'h0001, 1'b1, 2'd2, 0, 0);
    run_op(1, 16'h0000, 16'h0001, 1'b1, 2'd2, 0, 0);

    // words=0 with stalled consumer and a held request, then words=3
    run_op(0, 16'h12F0, 16'h3420, 1'b0, 2'd0, 3, 1);
    run_op(0, 16'h12F0, 16'h3420, 1'b0, 2'd0, 0, 0);
    run_op(1, 16'h1234, 16'h0235, 1'b1, 2'd3, 3, 0);
    run_op(5, 16'hBEEF, 16'h0000, 1'b0, 2'd2, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 5)), 16'($urandom), 16'($urandom), 1'($urandom),
             2'($urandom), int'($urandom_range(0, 2)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
